cpu_step_control: RTL and testbench
===================================

Name: cpu_step_control

Overview:
- Consumes the one-cycle press pulses from the board push-button debouncers and gates the SPC700 core's clock enable.
- Supports free run, halt, and single-instruction stepping, with a small queue of pending step requests.
- Keeps a retired-instruction counter for the board display.
- Sits between the button debouncers and the CPU core's enable input.

Parameters:
- START_RUNNING, 0: state after reset; 0 = HALT, 1 = RUN.
- PEND_W, 2: width of the pending-step counter; it saturates at 2^PEND_W-1.
- CNT_W, 16: width of the retired-instruction counter.

Ports:
- clk  input  1  system clock; everything sits on posedge.
- reset  input  1  synchronous, active-high reset.
- step_pressed  input  1  one-cycle pulse from the step button debouncer.
- run_pressed  input  1  one-cycle pulse from the run/stop button debouncer.
- instr_done  input  1  one-cycle pulse from the CPU on the cycle an instruction retires.
- cpu_enable  output  1  clock enable to the CPU core.
- running  output  1  high in RUN state (drives the status LED).
- halted  output  1  high in HALT state.
- pending_steps  output  PEND_W  queued step requests not yet begun.
- instr_count  output  CNT_W  retired-instruction count; wraps.

Behaviour:
- State register has four states: HALT, STEP, RUN, DRAIN.
- All outputs are decoded from registered state or registers only; no input-to-output combinational path.
- cpu_enable = (state != HALT); running = (state == RUN); halted = (state == HALT).
- Reset (synchronous, takes priority over all inputs):
  - state = RUN if START_RUNNING else HALT.
  - pending_steps = 0, instr_count = 0.
  - Outputs follow state in the first cycle after reset is released.
- Latency: a press pulse sampled at edge n changes state at edge n; the new cpu_enable is visible from edge n onward, i.e. one cycle after the pulse is presented.
- Priority in a single cycle: reset > run_pressed > instr_done > step_pressed.
- HALT:
  - run_pressed -> RUN.
  - else step_pressed -> STEP, pending_steps unchanged (0).
  - instr_done is ignored and not counted.
- STEP (CPU runs until the current instruction retires):
  - run_pressed -> RUN, pending_steps cleared to 0.
  - else, on instr_done:
    - if pending_steps > 0 (pre-update value): stay STEP, pending_steps decrements.
    - else -> HALT.
  - step_pressed without instr_done: pending_steps increments, saturating at max.
  - step_pressed with instr_done:
    - if pending > 0: net pending unchanged, stay STEP.
    - if pending == 0: stay STEP, pending stays 0 (the press is consumed as the next step).
- RUN:
  - run_pressed -> DRAIN.
  - step_pressed is ignored; pending_steps stays 0.
- DRAIN (stop requested; CPU finishes its current instruction):
  - run_pressed -> RUN (cancels the stop).
  - else instr_done -> HALT.
  - step_pressed is ignored.
- instr_count increments by 1 on every instr_done sampled while state != HALT, including the cycle that leaves STEP or DRAIN; it wraps from 2^CNT_W-1 to 0.
- Pending counter: never underflows; at saturation further presses are dropped silently.
- Glitch-free: cpu_enable never pulses low-high within one instruction while in STEP with pending > 0.
- Reset mid-STEP or mid-DRAIN:
  - Abandons the step or stop immediately and clears the counters.
  - An instr_done in the same cycle as reset is not counted.

Test Plan:
- Reset with START_RUNNING=0, then one step_pressed pulse -> cpu_enable rises the next cycle. Then instr_done 5 cycles later -> cpu_enable low the cycle after, halted=1, instr_count=1.
- In STEP with pending=0, step_pressed on three separate cycles before any instr_done (PEND_W=2) -> pending_steps=3. A fourth press leaves it at 3. Then 4 instr_done pulses -> pending counts 2,1,0, then HALT; instr_count=4, cpu_enable continuously high until HALT.
- HALT -> run_pressed -> RUN; step_pressed ignored (pending stays 0). Then run_pressed -> DRAIN with cpu_enable still 1; instr_done -> HALT.
- DRAIN, run_pressed coincident with instr_done -> RUN (run wins), instr_count still increments.
- STEP with pending=2, run_pressed and step_pressed in the same cycle -> RUN, pending_steps=0.
- Preload instr_count near wrap (CNT_W=4; run 15 instr_done in RUN), then one more instr_done -> instr_count=0. Then assert reset while in STEP coincident with instr_done -> halted=1, instr_count=0, pending=0 the next cycle.

Source files
------------

// File: rtl/cpu_step_control.sv
// Run/halt/single-step gate for the SPC700 clock enable, fed by debounced button pulses.
// Also counts retired instructions for the board display.
module cpu_step_control #(
  parameter bit START_RUNNING = 1'b0,
  parameter int PEND_W        = 2,
  parameter int CNT_W         = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              step_pressed,
  input  logic              run_pressed,
  input  logic              instr_done,
  output logic              cpu_enable,
  output logic              running,
  output logic              halted,
  output logic [PEND_W-1:0] pending_steps,
  output logic [CNT_W-1:0]  instr_count
);

  typedef enum logic [1:0] {
    S_HALT  = 2'd0,
    S_STEP  = 2'd1,
    S_RUN   = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  localparam logic [PEND_W-1:0] PEND_MAX = {PEND_W{1'b1}};
  localparam logic [PEND_W-1:0] PEND_ONE = {{(PEND_W-1){1'b0}}, 1'b1};
  localparam logic [PEND_W-1:0] PEND_ZERO = {PEND_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  CNT_ZERO = {CNT_W{1'b0}};
  localparam state_t            RESET_STATE = START_RUNNING ? S_RUN : S_HALT;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [PEND_W-1:0] r_pend;
  logic [PEND_W-1:0] w_pend_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_nxt;

  // State, pending-step and retired-instruction registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= RESET_STATE;
      r_pend  <= PEND_ZERO;
      r_cnt   <= CNT_ZERO;
    end else begin
      r_state <= w_state_nxt;
      r_pend  <= w_pend_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state logic; priority is run_pressed > instr_done > step_pressed.
  always_comb begin
    w_state_nxt = r_state;
    w_pend_nxt  = r_pend;
    w_cnt_nxt   = (instr_done && (r_state != S_HALT)) ? (r_cnt + CNT_ONE) : r_cnt;
    case (r_state)
      S_HALT: begin
        if (run_pressed) begin
          w_state_nxt = S_RUN;
        end else if (step_pressed) begin
          w_state_nxt = S_STEP;
        end else begin
          w_state_nxt = S_HALT;
        end
      end
      S_STEP: begin
        if (run_pressed) begin
          w_state_nxt = S_RUN;
          w_pend_nxt  = PEND_ZERO;
        end else if (instr_done) begin
          // A press landing on the retire cycle cancels the decrement (or becomes the next step).
          if (r_pend != PEND_ZERO) begin
            w_pend_nxt = step_pressed ? r_pend : (r_pend - PEND_ONE);
          end else if (!step_pressed) begin
            w_state_nxt = S_HALT;
          end else begin
            w_state_nxt = S_STEP;
          end
        end else if (step_pressed && (r_pend != PEND_MAX)) begin
          w_pend_nxt = r_pend + PEND_ONE;
        end else begin
          w_pend_nxt = r_pend;
        end
      end
      S_RUN: begin
        if (run_pressed) begin
          w_state_nxt = S_DRAIN;
        end else begin
          w_state_nxt = S_RUN;
        end
      end
      S_DRAIN: begin
        if (run_pressed) begin
          w_state_nxt = S_RUN;
        end else if (instr_done) begin
          w_state_nxt = S_HALT;
        end else begin
          w_state_nxt = S_DRAIN;
        end
      end
      default: begin
        w_state_nxt = RESET_STATE;
        w_pend_nxt  = PEND_ZERO;
      end
    endcase
  end

  // Output decode from registered state only.
  always_comb begin
    cpu_enable    = (r_state != S_HALT);
    running       = (r_state == S_RUN);
    halted        = (r_state == S_HALT);
    pending_steps = r_pend;
    instr_count   = r_cnt;
  end

endmodule

// File: tb/tb_cpu_step_control.sv
// Scoreboarded random/directed bench for cpu_step_control against an "instructions owed" model.
module tb_cpu_step_control;

  localparam int PEND_W = 2;
  localparam int CNT_W  = 4;
  localparam int PMAX   = (1 << PEND_W) - 1;

  localparam int M_HALT  = 0;
  localparam int M_STEP  = 1;
  localparam int M_RUN   = 2;
  localparam int M_DRAIN = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic step_pressed = 1'b0;
  logic run_pressed = 1'b0;
  logic instr_done = 1'b0;
  logic cpu_enable, running, halted;
  logic [PEND_W-1:0] pending_steps;
  logic [CNT_W-1:0]  instr_count;

  cpu_step_control #(.START_RUNNING(1'b0), .PEND_W(PEND_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .step_pressed(step_pressed), .run_pressed(run_pressed),
    .instr_done(instr_done), .cpu_enable(cpu_enable), .running(running), .halted(halted),
    .pending_steps(pending_steps), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic en;
    logic run;
    logic halt;
    int   pend;
    int   cnt;
  } exp_t;

  exp_t exp_q[$];
  int n_checks = 0;
  int n_fail = 0;

  // Model: mode plus number of instructions still owed to the user while stepping.
  int m_mode = M_HALT;
  int m_owed = 0;
  int m_cnt = 0;

  task automatic model_step(input logic rst, input logic st, input logic rn, input logic dn);
    if (rst) begin
      m_mode = M_HALT; m_owed = 0; m_cnt = 0;
      return;
    end
    if (dn && m_mode != M_HALT) m_cnt = (m_cnt + 1) % (1 << CNT_W);
    case (m_mode)
      M_HALT:  if (rn) m_mode = M_RUN; else if (st) begin m_mode = M_STEP; m_owed = 1; end
      M_STEP:  if (rn) begin m_mode = M_RUN; m_owed = 0; end
               else begin
                 if (dn) m_owed = m_owed - 1;
                 if (st) m_owed = (m_owed + 1 > PMAX + 1) ? PMAX + 1 : m_owed + 1;
                 if (m_owed == 0) m_mode = M_HALT;
               end
      M_RUN:   if (rn) m_mode = M_DRAIN;
      default: if (rn) m_mode = M_RUN; else if (dn) m_mode = M_HALT;
    endcase
  endtask

  task automatic cyc(input logic rst, input logic st, input logic rn, input logic dn);
    exp_t e;
    @(negedge clk);
    reset = rst; step_pressed = st; run_pressed = rn; instr_done = dn;
    model_step(rst, st, rn, dn);
    e.en = (m_mode != M_HALT);
    e.run = (m_mode == M_RUN);
    e.halt = (m_mode == M_HALT);
    e.pend = (m_mode == M_STEP) ? m_owed - 1 : 0;
    e.cnt = m_cnt;
    @(posedge clk);
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: each cycle the DUT presents a new output set; compare against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_checks++;
        if (cpu_enable !== e.en || running !== e.run || halted !== e.halt ||
            int'(pending_steps) != e.pend || int'(instr_count) != e.cnt) begin
          n_fail++;
          $display("FAIL outputs @%0t: got en=%0b run=%0b halt=%0b pend=%0d cnt=%0d, want en=%0b run=%0b halt=%0b pend=%0d cnt=%0d",
                   $time, cpu_enable, running, halted, pending_steps, instr_count,
                   e.en, e.run, e.halt, e.pend, e.cnt);
        end
      end
    end
  end

  initial begin
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    idle(2);
    // Single step, retire five cycles later.
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    idle(4);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    idle(2);
    // Queue three steps plus a dropped fourth, then retire all of them.
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin cyc(1'b0, 1'b1, 1'b0, 1'b0); idle(1); end
    for (int i = 0; i < 4; i++) begin idle(2); cyc(1'b0, 1'b0, 1'b0, 1'b1); end
    idle(2);
    // Run, ignored step, drain, halt.
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    idle(1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    // Drain cancelled by run coincident with retire.
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b1);
    // Back to HALT, step with pending=2, then run+step together.
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 1'b0);
    // Counter wrap in RUN.
    for (int i = 0; i < 16; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1);
    // Reset mid-step coincident with retire.
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
    idle(1);
    // Randomised traffic.
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) == 0),
          ($urandom_range(0, 9) == 0), ($urandom_range(0, 2) == 0));
    end
    idle(2);
    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
